// File: rtl/mem_bus_arb_pkg.sv
// rtl/mem_bus_arb_pkg.sv - shared types and constants for the memory bus arbiter
//
// Purpose: state and owner enums plus arbitration constants used by
//          mem_bus_arbiter and rr_pick2.
// Ports:   none (package).

package mem_bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_t;

    // Maximum consecutive m0 grants a held lock may win before it is
    // ignored for one arbitration.
    localparam int unsigned LOCK_MAX = 4;

    // Access counter width; covers WAIT_CYCLES up to 15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// rtl/mem_bus_arbiter_rr_pick2.sv - combinational two-way round-robin picker
//
// Purpose: chooses one of two requesters. A tie goes to the requester that
//          did not win last time; lock_force hands the grant to m0 whenever
//          m0 is requesting.
// Ports:
//   req[1:0]     in   request vector, bit 0 = m0, bit 1 = m1
//   last         in   owner of the previous grant
//   lock_force   in   force m0 when it requests
//   grant_valid  out  at least one request present
//   grant_id     out  selected owner (meaningful when grant_valid)

module rr_pick2
    import mem_bus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    input  logic       lock_force,
    output logic       grant_valid,
    output owner_t     grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = OWNER_M0;
        if (lock_force && req[0]) begin
            grant_id = OWNER_M0;
        end else if (req == 2'b11) begin
            grant_id = (last == OWNER_M0) ? OWNER_M1 : OWNER_M0;
        end else if (req == 2'b10) begin
            grant_id = OWNER_M1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter for the memory bus
//
// Purpose: shares one memory bus between m0 (CPU) and m1 (DMA/debug). A
//          granted access latches the owner's command, holds the strobe for
//          WAIT_CYCLES+1 cycles, captures read data on the last access cycle
//          and pulses the owner's done for one cycle.
// Optional: ARB_LOCK_EN adds m0_lock, letting m0 keep the bus across
//           consecutive accesses (bounded by LOCK_MAX grants).
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   mX_req/we/addr/wdata         requester command, held until mX_done
//   mX_done, mX_rdata            completion pulse and read data
//   m0_lock                      (ARB_LOCK_EN only) keep bus for m0
//   mem_read/write/addr/wdata    memory bus strobes and payload
//   mem_rdata                    memory read data
//   busy                         arbiter not idle

module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
`ifdef ARB_LOCK_EN
    input  logic              m0_lock,
`endif
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_l_q, we_l_d;
    logic [ADDR_W-1:0] addr_l_q, addr_l_d;
    logic [DATA_W-1:0] wdata_l_q, wdata_l_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              grant_valid;
    owner_t            grant_id;
    logic              lock_force;

`ifdef ARB_LOCK_EN
    // lock_pend_q: m0 finished with m0_lock set; honoured only in the very
    // next IDLE cycle. lock_cnt_q: consecutive m0 grants, saturating, so a
    // held lock yields to m1 once LOCK_MAX grants have gone to m0.
    logic       lock_pend_q, lock_pend_d;
    logic [2:0] lock_cnt_q, lock_cnt_d;

    assign lock_force = lock_pend_q && (lock_cnt_q < 3'(LOCK_MAX));

    always_comb begin
        lock_pend_d = lock_pend_q;
        lock_cnt_d  = lock_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                lock_pend_d = 1'b0;
                if (grant_valid) begin
                    if (grant_id == OWNER_M0) begin
                        if (lock_cnt_q != 3'd7) begin
                            lock_cnt_d = lock_cnt_q + 3'd1;
                        end
                    end else begin
                        lock_cnt_d = 3'd0;
                    end
                end
            end
            ARB_DONE: begin
                lock_pend_d = (owner_q == OWNER_M0) && m0_lock;
            end
            default: begin
                lock_pend_d = lock_pend_q;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_pend_q <= 1'b0;
            lock_cnt_q  <= 3'd0;
        end else begin
            lock_pend_q <= lock_pend_d;
            lock_cnt_q  <= lock_cnt_d;
        end
    end
`else
    assign lock_force = 1'b0;
`endif

    rr_pick2 u_pick (
        .req         ({m1_req, m0_req}),
        .last        (last_grant_q),
        .lock_force  (lock_force),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        we_l_d       = we_l_q;
        addr_l_d     = addr_l_q;
        wdata_l_d    = wdata_l_q;
        rdata_d      = rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    cnt_d        = '0;
                    if (grant_id == OWNER_M1) begin
                        we_l_d    = m1_we;
                        addr_l_d  = m1_addr;
                        wdata_l_d = m1_wdata;
                    end else begin
                        we_l_d    = m0_we;
                        addr_l_d  = m0_addr;
                        wdata_l_d = m0_wdata;
                    end
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // Last strobe cycle: memory data is valid now.
                if (cnt_q == CNT_LAST) begin
                    if (!we_l_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // last_grant resets to m1 so that m0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWNER_M0;
            last_grant_q <= OWNER_M1;
            cnt_q        <= '0;
            we_l_q       <= 1'b0;
            addr_l_q     <= '0;
            wdata_l_q    <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            we_l_q       <= we_l_d;
            addr_l_q     <= addr_l_d;
            wdata_l_q    <= wdata_l_d;
            rdata_q      <= rdata_d;
        end
    end

    // Outputs decode straight from state so an asynchronous reset drops the
    // strobes and busy in the same cycle.
    assign busy      = (state_q != ARB_IDLE);
    assign mem_read  = (state_q == ARB_ACCESS) && !we_l_q;
    assign mem_write = (state_q == ARB_ACCESS) && we_l_q;
    assign mem_addr  = addr_l_q;
    assign mem_wdata = wdata_l_q;
    assign m0_done   = (state_q == ARB_DONE) && (owner_q == OWNER_M0);
    assign m1_done   = (state_q == ARB_DONE) && (owner_q == OWNER_M1);
    assign m0_rdata  = rdata_q;
    assign m1_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter

module tb_mem_bus_arbiter;

    parameter int WAIT = 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_lat;
    } cmd_t;

    logic        clock;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_done, m1_done;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;
    logic        m0_lock;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic abort    = 1'b0;
    int   raise_cyc0 = 0;
    int   raise_cyc1 = 0;
    int   done_cnt0  = 0;
    int   done_cnt1  = 0;

    cmd_t cmd0_q[$];
    cmd_t cmd1_q[$];
    cmd_t exp0_q[$];
    cmd_t exp1_q[$];
    bit   order_q[$];

    mem_bus_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
`ifdef ARB_LOCK_EN
        .m0_lock   (m0_lock),
`endif
        .m0_done   (m0_done),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_done   (m1_done),
        .m1_rdata  (m1_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    assign mem_rdata = mem_model(mem_addr);

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic issue(input bit who, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic lat);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d; c.chk_lat = lat;
        if (who) begin
            cmd1_q.push_back(c);
            exp1_q.push_back(c);
        end else begin
            cmd0_q.push_back(c);
            exp0_q.push_back(c);
        end
        order_q.push_back(who);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((order_q.size() != 0 || cmd0_q.size() != 0 || cmd1_q.size() != 0 ||
                busy || m0_req || m1_req) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("idle_timeout", 32'(n < budget), 32'd1);
    endtask

    // Requester m0: holds req until its done is seen, then loads the next command.
    initial begin : drv0
        int   seen;
        cmd_t c;
        seen = 0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        forever begin
            @(posedge clock);
            #1;
            if (abort) begin
                m0_req = 1'b0;
                seen   = done_cnt0;
            end else begin
                if (m0_req && done_cnt0 != seen) begin
                    seen   = done_cnt0;
                    m0_req = 1'b0;
                end
                if (!m0_req && cmd0_q.size() > 0) begin
                    c = cmd0_q.pop_front();
                    m0_we = c.we; m0_addr = c.addr; m0_wdata = c.wdata;
                    m0_req = 1'b1;
                    raise_cyc0 = cyc;
                end
            end
        end
    end

    initial begin : drv1
        int   seen;
        cmd_t c;
        seen = 0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        forever begin
            @(posedge clock);
            #1;
            if (abort) begin
                m1_req = 1'b0;
                seen   = done_cnt1;
            end else begin
                if (m1_req && done_cnt1 != seen) begin
                    seen   = done_cnt1;
                    m1_req = 1'b0;
                end
                if (!m1_req && cmd1_q.size() > 0) begin
                    c = cmd1_q.pop_front();
                    m1_we = c.we; m1_addr = c.addr; m1_wdata = c.wdata;
                    m1_req = 1'b1;
                    raise_cyc1 = cyc;
                end
            end
        end
    end

    // Monitor: matches each bus access and done pulse against the scoreboard.
    initial begin : mon
        bit   in_acc;
        bit   cur_owner;
        int   width;
        cmd_t cur;
        cmd_t tmp;
        in_acc = 0; cur_owner = 0; width = 0;
        cur.we = 0; cur.addr = 0; cur.wdata = 0; cur.chk_lat = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_acc = 0;
            end else begin
                if (mem_read || mem_write) begin
                    check("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
                    if (!in_acc) begin
                        in_acc = 1;
                        width  = 0;
                        if (order_q.size() == 0) begin
                            check("unexpected_access", 32'd1, 32'd0);
                        end else begin
                            cur_owner = order_q.pop_front();
                            if (cur_owner && exp1_q.size() > 0) cur = exp1_q[0];
                            else if (!cur_owner && exp0_q.size() > 0) cur = exp0_q[0];
                        end
                    end
                    width++;
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_write", 32'(mem_write), 32'(cur.we));
                    if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                end
                if (m0_done || m1_done) begin
                    check("done_after_access", 32'(in_acc), 32'd1);
                    check("strobe_off_in_done", 32'(mem_read | mem_write), 32'd0);
                    check("m0_done", 32'(m0_done), 32'(cur_owner == 1'b0));
                    check("m1_done", 32'(m1_done), 32'(cur_owner == 1'b1));
                    check("strobe_width", 32'(width), 32'(WAIT + 1));
                    if (!cur.we)
                        check("rdata", cur_owner ? m1_rdata : m0_rdata, mem_model(cur.addr));
                    if (cur.chk_lat)
                        check("done_latency", 32'(cyc - (cur_owner ? raise_cyc1 : raise_cyc0)),
                              32'(WAIT + 2));
                    if (cur_owner) begin
                        if (exp1_q.size() > 0) tmp = exp1_q.pop_front();
                        done_cnt1++;
                    end else begin
                        if (exp0_q.size() > 0) tmp = exp0_q.pop_front();
                        done_cnt0++;
                    end
                    in_acc = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int polls;
        reset   = 1'b1;
        m0_lock = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_m0_done", 32'(m0_done), 32'd0);
        check("rst_m1_done", 32'(m1_done), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Single m0 read, then single m1 write.
        issue(1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b1);
        wait_idle(100);
        issue(1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 1'b1);
        wait_idle(100);

        // Both requesting continuously: strict alternation starting with m0.
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, logic'(i[0]), 32'h0000_1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0);
            issue(1'b1, logic'(~i[0]), 32'h0000_2000 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0);
        end
        wait_idle(400);

        // Reset in the second access cycle of an m1 read.
        issue(1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b0);
        polls = 0;
        while (!mem_read && polls < 20) begin
            @(negedge clock);
            polls++;
        end
        check("abort_read_started", 32'(mem_read), 32'd1);
        @(posedge clock);
        #2;
        abort = 1'b1;
        reset = 1'b1;
        #1;
        check("abort_mem_read", 32'(mem_read), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        order_q.delete();
        exp1_q.delete();
        cmd1_q.delete();
        repeat (2) begin
            @(negedge clock);
            check("abort_no_m1_done", 32'(m1_done), 32'd0);
        end
        reset = 1'b0;
        @(posedge clock);
        #2;
        abort = 1'b0;
        @(negedge clock);
        check("abort_no_m1_done_after", 32'(m1_done), 32'd0);
        issue(1'b0, 1'b0, 32'h0000_0400, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h0000_0500, 32'h0, 1'b0);
        wait_idle(200);

`ifdef ARB_LOCK_EN
        // Held lock: four m0 grants, one m1, four m0, one m1.
        m0_lock = 1'b1;
        for (int i = 0; i < 4; i++) issue(1'b0, 1'b0, 32'h0000_3000 + 32'(i * 4), 32'h0, 1'b0);
        issue(1'b1, 1'b1, 32'h0000_4000, 32'hC0DE_0001, 1'b0);
        for (int i = 4; i < 8; i++) issue(1'b0, 1'b0, 32'h0000_3000 + 32'(i * 4), 32'h0, 1'b0);
        issue(1'b1, 1'b1, 32'h0000_4004, 32'hC0DE_0002, 1'b0);
        wait_idle(600);
        m0_lock = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
